// File: rtl/epp_host_pkg.sv
// epp_host_pkg: shared definitions for the EPP host engine.
//   - EPP_OP_*  : command opcodes (bit1 selects strobe, bit0 selects read)
//   - state_t   : host cycle state machine encoding
package epp_host_pkg;

  localparam logic [1:0] EPP_OP_AW = 2'b00;  // address write
  localparam logic [1:0] EPP_OP_AR = 2'b01;  // address read
  localparam logic [1:0] EPP_OP_DW = 2'b10;  // data write
  localparam logic [1:0] EPP_OP_DR = 2'b11;  // data read

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    RELEASE
  } state_t;

endpackage

// File: rtl/epp_host_sync.sv
// sync: two-flop synchroniser for asynchronous inputs.
//   Parameters: BITS (vector width), INIT (reset value of both stages).
//   Ports: clk, rst (sync, active-high), d (async input), q (synchronised).
module sync #(
  parameter int unsigned     BITS = 1,
  parameter logic [BITS-1:0] INIT = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] d,
  output logic [BITS-1:0] q
);

  logic [BITS-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= INIT;
      q    <= INIT;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/epp_host.sv
// epp_host: EPP initiator. Turns single-byte commands into EPP address/data
// read/write cycles, completing each cycle on the peripheral's Wait handshake.
//   Command side : cmd_valid/cmd_ready/cmd_op/cmd_wdata
//   Response side: rsp_valid (1-cycle pulse), rsp_rdata (held), rsp_err, busy
//   EPP side     : Db (bidir), Astb/Dstb (active low), Wr (0 = host writes),
//                  Wait_unsync (asynchronous)
// Optional macro EPP_HOST_TIMEOUT_EN: abort STROBE/RELEASE after TIMEOUT_CYC
// cycles and report rsp_err=1. Undefined: waits forever, rsp_err tied 0.
module epp_host
  import epp_host_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = 3,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       busy,
  inout  logic [7:0] Db,
  output logic       Astb,
  output logic       Dstb,
  output logic       Wr,
  input  logic       Wait_unsync
);

`ifdef EPP_HOST_TIMEOUT_EN
  localparam int unsigned CNT_MAX = (SETUP_CYC > TIMEOUT_CYC) ? SETUP_CYC : TIMEOUT_CYC;
`else
  localparam int unsigned CNT_MAX = SETUP_CYC;
`endif
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             wr_q, wr_d;
  logic             astb_q, astb_d;
  logic             dstb_q, dstb_d;
  logic             oe_q, oe_d;
  logic             rv_q, rv_d;
  logic [7:0]       rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wait_s;
  logic [7:0]       db_s;

  sync #(.BITS(1), .INIT(1'b0)) u_wait_sync (
    .clk(clk), .rst(rst), .d(Wait_unsync), .q(wait_s)
  );

  sync #(.BITS(8), .INIT(8'h00)) u_db_sync (
    .clk(clk), .rst(rst), .d(Db), .q(db_s)
  );

  assign Db        = oe_q ? wdata_q : 'z;
  assign Astb      = astb_q;
  assign Dstb      = dstb_q;
  assign Wr        = wr_q;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rv_q;
  assign rsp_rdata = rdata_q;

`ifdef EPP_HOST_TIMEOUT_EN
  logic err_q, err_d;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    astb_d  = astb_q;
    dstb_d  = dstb_q;
    oe_d    = oe_q;
    rv_d    = 1'b0;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
`ifdef EPP_HOST_TIMEOUT_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          wdata_d = cmd_wdata;
          wr_d    = cmd_op[0];
          cnt_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        // Exit on the SETUP_CYC-th edge after accept so the strobe falls at k+SETUP_CYC.
        if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
          if (op_q[1]) dstb_d = 1'b0;
          else         astb_d = 1'b0;
          oe_d    = ~op_q[0];
          cnt_d   = '0;
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STROBE: begin
        if (wait_s) begin
          if (op_q[0]) rdata_d = db_s;
          astb_d  = 1'b1;
          dstb_d  = 1'b1;
          cnt_d   = '0;
          state_d = RELEASE;
        end
`ifdef EPP_HOST_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          astb_d  = 1'b1;
          dstb_d  = 1'b1;
          wr_d    = 1'b1;
          oe_d    = 1'b0;
          rv_d    = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RELEASE: begin
        if (!wait_s) begin
          wr_d    = 1'b1;
          oe_d    = 1'b0;
          rv_d    = 1'b1;
          state_d = IDLE;
        end
`ifdef EPP_HOST_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          wr_d    = 1'b1;
          oe_d    = 1'b0;
          rv_d    = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b1;
      astb_q  <= 1'b1;
      dstb_q  <= 1'b1;
      oe_q    <= 1'b0;
      rv_q    <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
`ifdef EPP_HOST_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      astb_q  <= astb_d;
      dstb_q  <= dstb_d;
      oe_q    <= oe_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
`ifdef EPP_HOST_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_epp_host.sv
// tb_epp_host: self-checking bench for epp_host with an EPP peripheral model,
// a response scoreboard and bus-protocol watchers. Honours EPP_HOST_TIMEOUT_EN.
module tb_epp_host;

  localparam int unsigned SETUP_CYC   = 3;
  localparam int unsigned TIMEOUT_CYC = 16;

  typedef struct {
    logic [1:0] op;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       err;
  } txn_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       busy;
  wire  [7:0] Db;
  logic       Astb, Dstb, Wr;
  logic       Wait_unsync;

  // peripheral-model drive (p_*) and directed-test drive (f_*)
  logic       periph_en = 1'b1;
  logic       p_wait = 1'b0, p_db_en = 1'b0;
  logic [7:0] p_db = 8'h00;
  logic       f_wait = 1'b0, f_db_en = 1'b0;
  logic [7:0] f_db = 8'h00;

  assign Wait_unsync = periph_en ? p_wait : f_wait;
  assign Db = p_db_en ? p_db : (f_db_en ? f_db : 8'bz);

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (Db[g]);
  end

  always #5 clk = ~clk;

  epp_host #(.SETUP_CYC(SETUP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .Db(Db),
    .Astb(Astb), .Dstb(Dstb), .Wr(Wr), .Wait_unsync(Wait_unsync)
  );

  int   checks = 0;
  int   errors = 0;
  int   rsp_count = 0;
  int   viol = 0;
  txn_t sbq[$];
  txn_t pq[$];
  logic [7:0] last_read = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Scoreboard monitor: every completion is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      txn_t e;
      rsp_count++;
      if (sbq.size() == 0) fail("unexpected_rsp");
      else begin
        e = sbq.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", rsp_err, e.err);
      end
    end
  end

  // EPP peripheral model: random Wait latency, serves reads, captures writes.
  always begin : periph
    @(negedge clk);
    if (periph_en && !rst && (!Astb || !Dstb)) begin
      txn_t t;
      int n;
      if (pq.size() == 0) fail("periph_unexpected_strobe");
      else begin
        t = pq.pop_front();
        chk("periph_strobe_is_data", !Dstb, t.op[1]);
        chk("periph_wr", Wr, t.op[0]);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (t.op[0]) begin
          p_db    = t.rdata;
          p_db_en = 1'b1;
        end else begin
          chk(t.op[1] ? "periph_data_byte" : "periph_addr_byte", Db, t.wdata);
        end
        p_wait = 1'b1;
        n = 0;
        while ((!Astb || !Dstb) && n < 64) begin
          @(negedge clk);
          n++;
        end
        if (n >= 64) fail("periph_strobe_release");
        p_db_en = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        p_wait = 1'b0;
      end
    end
  end

  // Protocol watcher: setup length, single strobe, Wr stability, undriven bus on reads.
  logic       trk = 1'b0;
  logic [1:0] trk_op = 2'b00;
  int         trk_cnt = 0;
  logic       prev_low = 1'b0, prev_wr = 1'b1;
  always @(negedge clk) begin
    if (rst) begin
      trk = 1'b0;
    end else begin
      if (!Astb && !Dstb) viol++;
      if (prev_low && (!Astb || !Dstb) && (Wr != prev_wr)) viol++;
      if (Wr && !p_db_en && !f_db_en && (Db !== 8'hFF)) viol++;
      if (trk) begin
        if (!Astb || !Dstb) begin
          chk("setup_cycles", trk_cnt, SETUP_CYC);
          trk = 1'b0;
        end else begin
          trk_cnt++;
          if (Wr != trk_op[0]) viol++;
        end
      end
      if (cmd_valid && cmd_ready) begin
        trk     = 1'b1;
        trk_op  = cmd_op;
        trk_cnt = 0;
      end
    end
    prev_low = !Astb || !Dstb;
    prev_wr  = Wr;
  end

  // Issue one command starting at a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic [1:0] op, input logic [7:0] wd, input logic [7:0] rd,
                       input bit hold, input bit to_periph, input bit exp_rsp,
                       input bit exp_err, output bit rdy_rsp);
    txn_t t;
    int n;
    if (exp_rsp && op[0] && !exp_err) last_read = rd;
    t.op = op; t.wdata = wd; t.rdata = last_read; t.err = exp_err;
    if (to_periph) begin
      t.rdata = rd;
      pq.push_back(t);
      t.rdata = last_read;
    end
    if (exp_rsp) sbq.push_back(t);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_wdata = wd;
    n = 0;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail("cmd_accept");
    rdy_rsp = rsp_valid;
    @(negedge clk);
    if (!hold) begin
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_wdata = 8'($urandom);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) fail("drain");
  endtask

  initial begin
    bit r;
    int n, low, rc;
    logic [1:0] op;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_astb", Astb, 1'b1);
    chk("reset_dstb", Dstb, 1'b1);
    chk("reset_wr", Wr, 1'b1);
    chk("reset_db_z", Db, 8'hFF);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_rdata", rsp_rdata, 8'h00);
    chk("reset_rsp_err", rsp_err, 1'b0);
    chk("reset_cmd_ready", cmd_ready, 1'b1);
    chk("reset_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // directed: address write, data read
    issue(2'b00, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, r);
    drain();
    issue(2'b11, 8'h00, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0, r);
    drain();
    chk("read_c3_held", rsp_rdata, 8'hC3);

    // back-to-back with cmd_valid held
    issue(2'b10, 8'h11, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, r);
    issue(2'b11, 8'h00, 8'hA7, 1'b0, 1'b1, 1'b1, 1'b0, r);
    chk("b2b_accept_after_rsp", r, 1'b1);
    drain();

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      bit hold;
      op   = 2'($urandom_range(0, 3));
      hold = ($urandom_range(0, 2) == 0) && (i < 39);
      issue(op, 8'($urandom), 8'($urandom), hold, 1'b1, 1'b1, 1'b0, r);
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    cmd_valid = 1'b0;
    drain();

    // reset while Dstb is low during a data write of 0x00
    periph_en = 1'b0;
    f_wait    = 1'b0;
    issue(2'b10, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, r);
    n = 0;
    while (Dstb && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) fail("mid_reset_strobe");
    repeat (3) @(negedge clk);
    rc  = rsp_count;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_dstb", Dstb, 1'b1);
    chk("midrst_astb", Astb, 1'b1);
    chk("midrst_wr", Wr, 1'b1);
    chk("midrst_db_z", Db, 8'hFF);
    chk("midrst_cmd_ready", cmd_ready, 1'b1);
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_no_rsp", rsp_count, rc);

    // Wait stuck high before the strobe
    f_db    = 8'h3C;
    f_db_en = 1'b1;
    f_wait  = 1'b1;
    repeat (4) @(negedge clk);
    issue(2'b11, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, r);
    n = 0;
    while (Dstb && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) fail("stuck_strobe");
    low = 0;
    while (!Dstb && low < 20) begin @(negedge clk); low++; end
    chk("stuck_strobe_low_cycles", low, 1);
    rc = rsp_count;
    repeat (10) @(negedge clk);
    chk("stuck_release_busy", busy, 1'b1);
    chk("stuck_release_no_rsp", rsp_count, rc);
    f_wait = 1'b0;
    n = 0;
    while (rsp_count == rc && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) fail("stuck_rsp");
    f_db_en = 1'b0;
    drain();

    // no peripheral response at all
`ifdef EPP_HOST_TIMEOUT_EN
    issue(2'b11, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, r);
    n = 0;
    while (Dstb && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) fail("timeout_strobe");
    low = 0;
    while (!Dstb && low < 200) begin @(negedge clk); low++; end
    chk("timeout_strobe_low_cycles", low, TIMEOUT_CYC);
    drain();
`else
    issue(2'b10, 8'h66, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, r);
    rc = rsp_count;
    repeat (120) @(negedge clk);
    chk("no_timeout_dstb_low", Dstb, 1'b0);
    chk("no_timeout_no_rsp", rsp_count, rc);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif
    periph_en = 1'b1;

    // one more transfer after the directed tests to confirm recovery
    issue(2'b01, 8'h00, 8'h9E, 1'b0, 1'b1, 1'b1, 1'b0, r);
    drain();

    chk("scoreboard_empty", sbq.size(), 0);
    chk("periph_queue_empty", pq.size(), 0);
    chk("protocol_violations", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
